chess_turn_controller: RTL and testbench
========================================

// Module: chess_turn_controller
// PURPOSE
//  Upstream game controller for the two player countdown timers.
//  - Converts raw start, move and pause pushbuttons into clean single-cycle events.
//  - Runs the turn state machine.
//  - Drives the 'flag' run-enable of the white and black countdown timers.
//  - Consumes their Timeout outputs to end the game and declare a result.
// PARAMETERS
//  DEBOUNCE_CYCLES  4    stable OutClock cycles needed before a button level is accepted (>=1)
//  CNT_W            3    width of debounce counter; must hold DEBOUNCE_CYCLES
//  MOVE_W           10   width of move_count
// PORTS
//  OutClock       in   1       clock, divider output; all logic rises on posedge
//  reset          in   1       asynchronous, active-high
//  start_btn      in   1       raw pushbutton, active-high, asynchronous to OutClock
//  white_btn      in   1       raw pushbutton: white finished move
//  black_btn      in   1       raw pushbutton: black finished move
//  pause_btn      in   1       raw pushbutton; used only with CHESS_PAUSE_EN
//  white_timeout  in   1       Timeout from white countdown timer
//  black_timeout  in   1       Timeout from black countdown timer
//  white_flag     out  1       run enable to white timer
//  black_flag     out  1       run enable to black timer
//  turn           out  1       0 = white to move, 1 = black to move
//  game_over      out  1       high in S_OVER
//  winner         out  2       00 none, 01 white, 10 black, 11 draw
//  move_count     out  MOVE_W  completed half-moves
// BEHAVIOUR
//  Reset (async, active-high), all registers cleared:
//   - state=S_IDLE; all outputs 0; sync, debounce and edge registers 0.
//  Input conditioning, per button:
//   - 2-flop synchronizer, then debounce counter.
//   - Counter resets whenever the synced value equals the debounced level.
//   - Otherwise the counter increments; at DEBOUNCE_CYCLES the level toggles and the counter clears.
//   - Event pulse = debounced & ~debounced_q; exactly one cycle per press; release gives no event.
//  Latency: raw input high before edge 0, stable.
//   - Debounced level rises at edge 2+DEBOUNCE_CYCLES.
//   - FSM and outputs update at edge 3+DEBOUNCE_CYCLES.
//  FSM states: S_IDLE, S_WHITE, S_BLACK, S_PAUSE (macro only), S_OVER.
//   S_IDLE  -> start event -> S_WHITE
//   S_WHITE -> white event -> S_BLACK; move_count+1
//   S_BLACK -> black event -> S_WHITE; move_count+1
//   Any run state, either timeout high -> S_OVER
//   S_OVER  -> held until reset; all button events ignored
//  Priority in the same cycle: timeout > pause > move event.
//  Event from the non-moving player's button is ignored.
//  Simultaneous white and black events: only the side to move is honoured.
//  Result on entry to S_OVER:
//   - winner=10 if only white_timeout; 01 if only black_timeout; 11 if both.
//   - winner is latched; later timeout changes do not alter it.
//  Timeout inputs are ignored in S_IDLE.
//  Outputs are registered from the next state:
//   - white_flag=(state==S_WHITE); black_flag=(state==S_BLACK).
//   - turn=1 in S_BLACK, also in S_PAUSE when paused from S_BLACK; 0 otherwise.
//   - Never both flags high.
//  move_count saturates at all-ones; it does not wrap.
//  Reset mid-game: immediate return to S_IDLE; flags drop asynchronously.
// CONFIGURATION
//  CHESS_PAUSE_EN defined:
//   - pause event in S_WHITE/S_BLACK -> S_PAUSE; both flags 0; turn remembered.
//   - pause event in S_PAUSE -> back to the remembered side.
//   - Move and start events in S_PAUSE are ignored; timeouts in S_PAUSE are ignored.
//  CHESS_PAUSE_EN undefined:
//   - S_PAUSE not built; pause_btn unused (port kept); pause events have no effect.
// TESTING  (DEBOUNCE_CYCLES=4)
//  Reset, then start_btn high for 10 cycles:
//   - white_flag=1 at edge 7, turn=0, move_count=0.
//  In S_WHITE, white_btn bounces 1-0-1 within 3 cycles, then stays high:
//   - exactly one transition; black_flag=1, turn=1, move_count=1.
//  In S_BLACK, press white_btn, then black_btn and white_btn together:
//   - first press ignored; second gives S_WHITE, move_count=2.
//  In S_WHITE, white_timeout=1 on the same edge a white event occurs:
//   - S_OVER, winner=10, both flags 0; further presses ignored.
//  Both timeouts rise in the same cycle -> winner=11.
//  Assert reset mid-game -> all outputs 0 immediately.
//  CHESS_PAUSE_EN: pause in S_BLACK -> flags 00, turn=1; pause again -> black_flag=1.

Source files
------------

// File: rtl/chess_turn_controller.sv
// Chess clock turn controller: debounces the pushbuttons, runs the turn FSM, drives the timer run-enables.
// Optional pause feature is built when CHESS_PAUSE_EN is defined.
module chess_turn_controller #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 3,
    parameter int MOVE_W          = 10
) (
    input  logic              OutClock,
    input  logic              reset,
    input  logic              start_btn,
    input  logic              white_btn,
    input  logic              black_btn,
    input  logic              pause_btn,
    input  logic              white_timeout,
    input  logic              black_timeout,
    output logic              white_flag,
    output logic              black_flag,
    output logic              turn,
    output logic              game_over,
    output logic [1:0]        winner,
    output logic [MOVE_W-1:0] move_count
);

`ifdef CHESS_PAUSE_EN
    localparam int unsigned NB = 4;
`else
    localparam int unsigned NB = 3;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_WHITE,
        S_BLACK,
`ifdef CHESS_PAUSE_EN
        S_PAUSE,
`endif
        S_OVER
    } state_t;

    logic [NB-1:0]     w_raw;
    logic [NB-1:0]     r_sync1;
    logic [NB-1:0]     r_sync2;
    logic [NB-1:0]     r_deb;
    logic [NB-1:0]     r_deb_q;
    logic [NB-1:0]     w_ev;
    logic [CNT_W-1:0]  r_cnt [NB];

`ifdef CHESS_PAUSE_EN
    assign w_raw = {pause_btn, black_btn, white_btn, start_btn};
`else
    logic w_unused_pause;
    assign w_unused_pause = pause_btn;
    assign w_raw = {black_btn, white_btn, start_btn};
`endif

    // Level toggles only after the synced input has disagreed for DEBOUNCE_CYCLES+1 consecutive edges.
    always_ff @(posedge OutClock or posedge reset) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_deb   <= '0;
            r_deb_q <= '0;
            for (int unsigned i = 0; i < NB; i++) r_cnt[i] <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            r_deb_q <= r_deb;
            for (int unsigned i = 0; i < NB; i++) begin
                if (r_sync2[i] == r_deb[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_W'(DEBOUNCE_CYCLES)) begin
                    r_deb[i] <= ~r_deb[i];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign w_ev = r_deb & ~r_deb_q;

    logic w_start_ev;
    logic w_white_ev;
    logic w_black_ev;
    logic w_any_to;
    assign w_start_ev = w_ev[0];
    assign w_white_ev = w_ev[1];
    assign w_black_ev = w_ev[2];
    assign w_any_to   = white_timeout | black_timeout;
`ifdef CHESS_PAUSE_EN
    logic w_pause_ev;
    assign w_pause_ev = w_ev[3];
`endif

    state_t            r_state;
    logic              r_white_flag;
    logic              r_black_flag;
    logic              r_turn;
    logic              r_game_over;
    logic [1:0]        r_winner;
    logic [MOVE_W-1:0] r_move_count;
    logic [MOVE_W-1:0] w_move_inc;

    assign w_move_inc = (r_move_count == '1) ? r_move_count : r_move_count + 1'b1;

    // Outputs are assigned alongside each transition so they always reflect the state being entered.
    always_ff @(posedge OutClock or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_white_flag <= 1'b0;
            r_black_flag <= 1'b0;
            r_turn       <= 1'b0;
            r_game_over  <= 1'b0;
            r_winner     <= '0;
            r_move_count <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start_ev) begin
                        r_state      <= S_WHITE;
                        r_white_flag <= 1'b1;
                    end
                end
                S_WHITE: begin
                    if (w_any_to) begin
                        r_state      <= S_OVER;
                        r_white_flag <= 1'b0;
                        r_black_flag <= 1'b0;
                        r_turn       <= 1'b0;
                        r_game_over  <= 1'b1;
                        r_winner     <= {white_timeout, black_timeout};
                    end
`ifdef CHESS_PAUSE_EN
                    else if (w_pause_ev) begin
                        r_state      <= S_PAUSE;
                        r_white_flag <= 1'b0;
                    end
`endif
                    else if (w_white_ev) begin
                        r_state      <= S_BLACK;
                        r_white_flag <= 1'b0;
                        r_black_flag <= 1'b1;
                        r_turn       <= 1'b1;
                        r_move_count <= w_move_inc;
                    end
                end
                S_BLACK: begin
                    if (w_any_to) begin
                        r_state      <= S_OVER;
                        r_white_flag <= 1'b0;
                        r_black_flag <= 1'b0;
                        r_turn       <= 1'b0;
                        r_game_over  <= 1'b1;
                        r_winner     <= {white_timeout, black_timeout};
                    end
`ifdef CHESS_PAUSE_EN
                    else if (w_pause_ev) begin
                        r_state      <= S_PAUSE;
                        r_black_flag <= 1'b0;
                    end
`endif
                    else if (w_black_ev) begin
                        r_state      <= S_WHITE;
                        r_white_flag <= 1'b1;
                        r_black_flag <= 1'b0;
                        r_turn       <= 1'b0;
                        r_move_count <= w_move_inc;
                    end
                end
`ifdef CHESS_PAUSE_EN
                S_PAUSE: begin
                    // r_turn is held through the pause and selects the side to resume.
                    if (w_pause_ev) begin
                        if (r_turn) begin
                            r_state      <= S_BLACK;
                            r_black_flag <= 1'b1;
                        end else begin
                            r_state      <= S_WHITE;
                            r_white_flag <= 1'b1;
                        end
                    end
                end
`endif
                S_OVER: begin
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_white_flag <= 1'b0;
                    r_black_flag <= 1'b0;
                    r_turn       <= 1'b0;
                end
            endcase
        end
    end

    assign white_flag = r_white_flag;
    assign black_flag = r_black_flag;
    assign turn       = r_turn;
    assign game_over  = r_game_over;
    assign winner     = r_winner;
    assign move_count = r_move_count;

endmodule

// File: tb/tb_chess_turn_controller.sv
// Self-checking bench for chess_turn_controller: behavioural game model compared every cycle plus literal checks.
// Pause scenarios follow CHESS_PAUSE_EN when it is defined.
module tb_chess_turn_controller;

    localparam int DC   = 4;
    localparam int MW   = 3;
    localparam int MAXM = (1 << MW) - 1;
    localparam int P_IDLE = 0, P_WHITE = 1, P_BLACK = 2, P_PAUSE = 3, P_OVER = 4;

    logic          OutClock = 1'b0;
    logic          reset = 1'b1;
    logic          start_btn = 1'b0, white_btn = 1'b0, black_btn = 1'b0, pause_btn = 1'b0;
    logic          white_timeout = 1'b0, black_timeout = 1'b0;
    logic          white_flag, black_flag, turn, game_over;
    logic [1:0]    winner;
    logic [MW-1:0] move_count;

    chess_turn_controller #(
        .DEBOUNCE_CYCLES(DC),
        .CNT_W(3),
        .MOVE_W(MW)
    ) dut (
        .OutClock(OutClock),
        .reset(reset),
        .start_btn(start_btn),
        .white_btn(white_btn),
        .black_btn(black_btn),
        .pause_btn(pause_btn),
        .white_timeout(white_timeout),
        .black_timeout(black_timeout),
        .white_flag(white_flag),
        .black_flag(black_flag),
        .turn(turn),
        .game_over(game_over),
        .winner(winner),
        .move_count(move_count)
    );

    always #5 OutClock = ~OutClock;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: raw history per edge, accepted levels, and the game position.
    bit raw_at [4][0:19999];
    int m_k;
    bit m_lvl [4];
    int m_run [4];
    bit m_ev  [4];
    int m_phase;
    bit m_side;
    int m_mc;
    int m_win;
    bit m_raw [4];
    bit m_seen;
    bit m_pause_on;

`ifdef CHESS_PAUSE_EN
    initial m_pause_on = 1'b1;
`else
    initial m_pause_on = 1'b0;
`endif

    always @(posedge OutClock or posedge reset) begin
        if (reset) begin
            m_k = 0; m_phase = P_IDLE; m_side = 0; m_mc = 0; m_win = 0;
            for (int b = 0; b < 4; b++) begin
                m_lvl[b] = 0; m_run[b] = 0; m_ev[b] = 0;
            end
        end else begin
            case (m_phase)
                P_IDLE: if (m_ev[0]) m_phase = P_WHITE;
                P_WHITE, P_BLACK: begin
                    if (white_timeout || black_timeout) begin
                        m_phase = P_OVER;
                        m_win = (white_timeout ? 2 : 0) + (black_timeout ? 1 : 0);
                    end else if (m_pause_on && m_ev[3]) begin
                        m_side = (m_phase == P_BLACK);
                        m_phase = P_PAUSE;
                    end else if (m_phase == P_WHITE && m_ev[1]) begin
                        m_phase = P_BLACK;
                        m_mc = (m_mc < MAXM) ? m_mc + 1 : MAXM;
                    end else if (m_phase == P_BLACK && m_ev[2]) begin
                        m_phase = P_WHITE;
                        m_mc = (m_mc < MAXM) ? m_mc + 1 : MAXM;
                    end
                end
                P_PAUSE: if (m_ev[3]) m_phase = m_side ? P_BLACK : P_WHITE;
                default: ;
            endcase
            m_raw[0] = start_btn; m_raw[1] = white_btn; m_raw[2] = black_btn; m_raw[3] = pause_btn;
            for (int b = 0; b < 4; b++) begin
                raw_at[b][m_k] = m_raw[b];
                m_seen = (m_k >= 2) ? raw_at[b][m_k-2] : 1'b0;
                m_ev[b] = 0;
                if (m_seen != m_lvl[b]) m_run[b]++;
                else m_run[b] = 0;
                if (m_run[b] == DC + 1) begin
                    m_lvl[b] = ~m_lvl[b];
                    m_run[b] = 0;
                    m_ev[b] = m_lvl[b];
                end
            end
            if (m_k < 19999) m_k++;
        end
    end

    always @(negedge OutClock) begin
        if (!reset) begin
            chk("white_flag", white_flag, m_phase == P_WHITE);
            chk("black_flag", black_flag, m_phase == P_BLACK);
            chk("turn", turn, (m_phase == P_BLACK) || (m_phase == P_PAUSE && m_side));
            chk("game_over", game_over, m_phase == P_OVER);
            chk("winner", winner, m_win);
            chk("move_count", move_count, m_mc);
            chk("flags_exclusive", white_flag & black_flag, 0);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge OutClock);
    endtask

    task automatic set_btn(input int idx, input logic v);
        case (idx)
            0: start_btn = v;
            1: white_btn = v;
            2: black_btn = v;
            default: pause_btn = v;
        endcase
    endtask

    task automatic press(input int idx);
        set_btn(idx, 1'b1);
        cyc(10);
        set_btn(idx, 1'b0);
        cyc(10);
    endtask

    task automatic do_reset();
        @(negedge OutClock);
        #2 reset = 1'b1;
        cyc(2);
        #2 reset = 1'b0;
        cyc(1);
    endtask

    initial begin
        cyc(3);
        chk("rst_flags", {white_flag, black_flag, turn, game_over}, 0);
        chk("rst_winner", winner, 0);
        chk("rst_mc", move_count, 0);
        #2 reset = 1'b0;
        cyc(1);

        // Timeout in idle has no effect
        white_timeout = 1'b1;
        cyc(3);
        white_timeout = 1'b0;
        cyc(1);
        chk("idle_to_ignored", game_over, 0);

        // Start: white_flag rises at edge 7 exactly
        start_btn = 1'b1;
        cyc(7);
        chk("start_edge6", white_flag, 0);
        cyc(1);
        chk("start_edge7", white_flag, 1);
        chk("start_turn", turn, 0);
        chk("start_mc", move_count, 0);
        cyc(2);
        start_btn = 1'b0;
        cyc(10);

        // Bouncing white button gives a single move
        white_btn = 1'b1; cyc(1);
        white_btn = 1'b0; cyc(1);
        white_btn = 1'b1; cyc(10);
        white_btn = 1'b0; cyc(10);
        chk("bounce_bflag", black_flag, 1);
        chk("bounce_turn", turn, 1);
        chk("bounce_mc", move_count, 1);

        // Wrong-side press ignored, then simultaneous press honours black
        press(1);
        chk("wrong_side_bflag", black_flag, 1);
        chk("wrong_side_mc", move_count, 1);
        white_btn = 1'b1; black_btn = 1'b1;
        cyc(10);
        white_btn = 1'b0; black_btn = 1'b0;
        cyc(10);
        chk("both_wflag", white_flag, 1);
        chk("both_mc", move_count, 2);

        // Pause in S_BLACK
        press(1);
        press(3);
`ifdef CHESS_PAUSE_EN
        chk("pause_flags", {white_flag, black_flag}, 0);
        chk("pause_turn", turn, 1);
`else
        chk("nopause_bflag", black_flag, 1);
`endif
        press(3);
        chk("resume_bflag", black_flag, 1);
        press(2);
        chk("after_pause_mc", move_count, 4);

        // White timeout coincides with a white move event
        white_btn = 1'b1;
        cyc(7);
        white_timeout = 1'b1;
        cyc(1);
        chk("to_over", game_over, 1);
        chk("to_winner", winner, 2);
        chk("to_flags", {white_flag, black_flag}, 0);
        white_btn = 1'b0;
        cyc(3);
        white_timeout = 1'b0;
        press(2);
        press(0);
        chk("over_held", game_over, 1);
        chk("over_winner", winner, 2);

        // Second game: saturation then simultaneous timeouts
        do_reset();
        press(0);
        for (int m = 0; m < 9; m++) press((m % 2 == 0) ? 1 : 2);
        chk("sat_mc", move_count, MAXM);
        chk("sat_turn", turn, 1);
        white_timeout = 1'b1; black_timeout = 1'b1;
        cyc(1);
        chk("draw_winner", winner, 3);
        white_timeout = 1'b0;
        cyc(2);
        black_timeout = 1'b0;
        cyc(2);
        chk("draw_latched", winner, 3);

        // Third game: black timeout while white to move
        do_reset();
        press(0);
        black_timeout = 1'b1;
        cyc(1);
        chk("bto_winner", winner, 1);
        black_timeout = 1'b0;
        cyc(3);

        // Asynchronous reset mid-game
        do_reset();
        press(0);
        press(1);
        chk("pre_rst_bflag", black_flag, 1);
        @(negedge OutClock);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_flags", {white_flag, black_flag, turn, game_over}, 0);
        chk("async_rst_mc", move_count, 0);
        cyc(2);
        #2 reset = 1'b0;
        cyc(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
